// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the single-port debug monitor RAM between JTAG ocimem actions and the CPU debug-slave port.
// JTAG actions are decoded into one pending slot; a round-robin arbiter grants the RAM to JTAG or CPU.
module nios2_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        CRD  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_JTAG = 1'b1
    } grant_t;

    state_t              state;
    state_t              state_next;
    grant_t              last_grant;
    logic                active;
    logic                jtag_pend;
    logic                jtag_is_wr;
    logic [31:0]         jtag_wdata;
    logic [ADDR_W-1:0]   mon_a_reg;

    logic                pulse_load;
    logic                queue_rd;
    logic                queue_wr;
    logic                queue_any;
    logic                overrun;
    logic                accept_load;
    logic                accept_op;
    logic                cpu_req;
    logic                grant_jtag;
    logic                grant_cpu;
    logic                jtag_done;
    logic                unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

    // A pulse arriving while an operation is still pending is dropped whole, address load included.
    assign pulse_load  = take_action_ocimem_a & jdo[34];
    assign queue_rd    = (take_action_ocimem_a & jdo[35]) | take_no_action_ocimem_a;
    assign queue_wr    = take_action_ocimem_b;
    assign queue_any   = queue_rd | queue_wr;
    assign overrun     = queue_any & jtag_pend;
    assign accept_load = pulse_load & ~jtag_pend;
    assign accept_op   = queue_any & ~jtag_pend;

    assign cpu_req       = cpu_read | cpu_write;
    assign monitor_ready = ~jtag_pend;

    // 'active' holds off grants for the first cycle after reset so a held CPU request
    // cannot reach the RAM while reset is asserted.
    always_comb begin
        state_next      = state;
        grant_jtag      = 1'b0;
        grant_cpu       = 1'b0;
        jtag_done       = 1'b0;
        ram_address     = '0;
        ram_wren        = 1'b0;
        ram_byteenable  = '0;
        ram_wdata       = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = '0;

        case (state)
            IDLE: begin
                if (active) begin
                    if (jtag_pend && (!cpu_req || last_grant == GRANT_CPU)) begin
                        grant_jtag = 1'b1;
                    end else if (cpu_req) begin
                        grant_cpu = 1'b1;
                    end
                end

                if (grant_jtag) begin
                    ram_address    = mon_a_reg;
                    ram_byteenable = 4'hF;
                    if (jtag_is_wr) begin
                        ram_wren  = 1'b1;
                        ram_wdata = jtag_wdata;
                        jtag_done = 1'b1;
                    end else begin
                        state_next = JRD;
                    end
                end else if (grant_cpu) begin
                    ram_address    = cpu_address;
                    ram_byteenable = cpu_byteenable;
                    if (cpu_write) begin
                        ram_wren        = 1'b1;
                        ram_wdata       = cpu_writedata;
                        cpu_waitrequest = 1'b0;
                    end else begin
                        state_next = CRD;
                    end
                end
            end

            JRD: begin
                jtag_done  = 1'b1;
                state_next = IDLE;
            end

            CRD: begin
                cpu_readdata    = ram_rdata;
                cpu_waitrequest = 1'b0;
                state_next      = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= GRANT_CPU;
            active     <= 1'b0;
        end else begin
            state  <= state_next;
            active <= 1'b1;
            if (grant_jtag) begin
                last_grant <= GRANT_JTAG;
            end else if (grant_cpu) begin
                last_grant <= GRANT_CPU;
            end
        end
    end

    // Load and completion never collide: a load is only accepted while nothing is pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_pend     <= 1'b0;
            jtag_is_wr    <= 1'b0;
            jtag_wdata    <= '0;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
        end else begin
            if (jtag_done) begin
                jtag_pend <= 1'b0;
                mon_a_reg <= mon_a_reg + 1'b1;
            end

            if (state == JRD) begin
                MonDReg <= ram_rdata;
            end

            if (accept_load) begin
                mon_a_reg <= jdo[ADDR_W+16:17];
            end

            if (accept_op) begin
                jtag_pend  <= 1'b1;
                jtag_is_wr <= queue_wr;
                jtag_wdata <= jdo[34:3];
            end

            if (overrun) begin
                monitor_error <= 1'b1;
            end else if (accept_load) begin
                monitor_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Randomized self-checking bench: a transaction-level model of the monitor RAM and JTAG address
// pointer predicts every JTAG and CPU result; a behavioural 1-cycle RAM sits on the RAM port.
module tb_nios2_debug_ocimem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_wren;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    nios2_debug_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_address             (ram_address),
        .ram_wren                (ram_wren),
        .ram_byteenable          (ram_byteenable),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM with a preload port used only while the DUT is held in reset.
    logic [31:0]       ram [DEPTH];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;
    int                wren_count = 0;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteenable[b]) ram[ram_address][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= ram[ram_address];
        if (ram_wren) wren_count <= wren_count + 1;
    end

    logic [31:0]       model_mem [DEPTH];
    logic [ADDR_W-1:0] model_addr;
    int                total_checks = 0;
    int                bad_checks   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] mkLoad(input logic [ADDR_W-1:0] a, input logic rd);
        logic [37:0] v;
        v = '0;
        v[34] = 1'b1;
        v[35] = rd;
        v[ADDR_W+16:17] = a;
        return v;
    endfunction

    function automatic logic [37:0] mkWrite(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a; one-cycle pulse.
    task automatic applyStimulus(input int kind, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        @(negedge clk);
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic waitReady(output int low);
        low = 0;
        for (int i = 0; i < 40 && !monitor_ready; i++) begin
            low++;
            @(negedge clk);
        end
        if (!monitor_ready) checkOutput("ready_timeout", {31'd0, monitor_ready}, 32'd1);
    endtask

    task automatic jtagLoad(input logic [ADDR_W-1:0] a, input logic rd);
        int low;
        applyStimulus(0, mkLoad(a, rd));
        model_addr = a;
        checkOutput("load_err_clr", {31'd0, monitor_error}, 32'd0);
        if (rd) begin
            waitReady(low);
            checkOutput("load_rd_data", MonDReg, model_mem[model_addr]);
            checkOutput("load_rd_low", low, 2);
            model_addr++;
        end else begin
            checkOutput("load_ready", {31'd0, monitor_ready}, 32'd1);
        end
    endtask

    task automatic jtagRead(input string tag, input bit check_low);
        int low;
        applyStimulus(2, '0);
        waitReady(low);
        checkOutput({tag, "_data"}, MonDReg, model_mem[model_addr]);
        if (check_low) checkOutput({tag, "_low"}, low, 2);
        model_addr++;
    endtask

    task automatic jtagWrite(input string tag, input logic [31:0] d);
        int low;
        int w0;
        w0 = wren_count;
        applyStimulus(1, mkWrite(d));
        waitReady(low);
        model_mem[model_addr] = d;
        checkOutput({tag, "_low"}, low, 1);
        checkOutput({tag, "_wren"}, wren_count - w0, 1);
        checkOutput({tag, "_ram"}, ram[model_addr], d);
        model_addr++;
    endtask

    task automatic cpuRead(input string tag, input logic [ADDR_W-1:0] a);
        int lat;
        bit done;
        logic [31:0] got;
        cpu_address = a;
        cpu_read    = 1'b1;
        lat  = 1;
        done = 1'b0;
        got  = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_waitrequest) begin
                done = 1'b1;
                got  = cpu_readdata;
                break;
            end
            @(negedge clk);
            lat++;
        end
        cpu_read = 1'b0;
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_data"}, got, model_mem[a]);
        checkOutput({tag, "_lat_le4"}, {31'd0, (lat <= 4)}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput({tag, "_one_cycle"}, {31'd0, cpu_waitrequest}, 32'd1);
    endtask

    task automatic cpuWrite(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        int w0;
        bit done;
        w0 = wren_count;
        cpu_address    = a;
        cpu_writedata  = d;
        cpu_byteenable = be;
        cpu_write      = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cpu_waitrequest) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cpu_write      = 1'b0;
        cpu_byteenable = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, "_wren"}, wren_count - w0, 1);
        checkOutput({tag, "_ram"}, ram[a], model_mem[a]);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        int low;
        int op;

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        model_addr = '0;

        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            pl_addr = ADDR_W'(a);
            pl_data = $urandom;
            if (a == 'h10) pl_data = 32'hDEADBEEF;
            if (a == 'h11) pl_data = 32'h11111111;
            if (a == 'h05) pl_data = 32'hFFFFFFFF;
            if (a == 'h20) pl_data = 32'hC0FFEE20;
            model_mem[a] = pl_data;
            pl_en = 1'b1;
            @(negedge clk);
        end
        pl_en = 1'b0;

        // Reset state, with a CPU write held to show nothing reaches the RAM during reset.
        cpu_write = 1'b1;
        cpu_address = 8'h07;
        cpu_byteenable = 4'hF;
        cpu_writedata = 32'hBAD0BAD0;
        #1;
        checkOutput("rst_mondreg", MonDReg, 32'd0);
        checkOutput("rst_ready", {31'd0, monitor_ready}, 32'd1);
        checkOutput("rst_error", {31'd0, monitor_error}, 32'd0);
        checkOutput("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
        checkOutput("rst_wren", {31'd0, ram_wren}, 32'd0);
        checkOutput("rst_ram_addr", {24'd0, ram_address}, 32'd0);
        checkOutput("rst_ram_be", {28'd0, ram_byteenable}, 32'd0);
        checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
        checkOutput("rst_cpu_rdata", cpu_readdata, 32'd0);
        @(negedge clk);
        cpu_write = 1'b0;
        cpu_byteenable = '0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] address load then read");
        jtagLoad(8'h10, 1'b0);
        jtagRead("rd_10", 1'b1);
        jtagRead("rd_11", 1'b1);

        $display("[TB] write burst with wrap");
        jtagLoad(8'hFE, 1'b0);
        jtagWrite("burst_a", 32'hAAAA0001);
        repeat (2) @(negedge clk);
        jtagWrite("burst_b", 32'hBBBB0002);
        repeat (2) @(negedge clk);
        jtagWrite("burst_c", 32'hCCCC0003);
        checkOutput("wrap_ram_fe", ram[8'hFE], 32'hAAAA0001);
        checkOutput("wrap_ram_ff", ram[8'hFF], 32'hBBBB0002);
        checkOutput("wrap_ram_00", ram[8'h00], 32'hCCCC0003);
        jtagRead("rd_after_wrap", 1'b1);

        $display("[TB] overrun");
        w0 = wren_count;
        jdo = mkWrite(32'h0000AAAA);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        jdo = mkWrite(32'h0000BBBB);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        waitReady(low);
        model_mem[model_addr] = 32'h0000AAAA;
        model_addr++;
        checkOutput("ovr_error_set", {31'd0, monitor_error}, 32'd1);
        checkOutput("ovr_one_write", wren_count - w0, 1);
        jtagLoad(model_addr, 1'b0);
        jtagRead("ovr_rd", 1'b1);

        $display("[TB] cpu byte-enable write");
        cpuWrite("cpu_be", 8'h05, 32'h12345678, 4'h3);
        checkOutput("cpu_be_merge", ram[5], 32'hFFFF5678);
        cpuRead("cpu_rd5", 8'h05);

        $display("[TB] contention");
        jtagLoad(8'h40, 1'b0);
        fork
            begin
                for (int k = 0; k < 4; k++) cpuRead("cont_cpu", 8'h20);
            end
            begin
                for (int k = 0; k < 4; k++) jtagRead("cont_jtag", 1'b0);
            end
        join
        jtagRead("cont_after", 1'b1);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: jtagLoad(ADDR_W'($urandom), 1'($urandom_range(0, 1)));
                1: jtagWrite("rnd_jwr", $urandom);
                2: jtagRead("rnd_jrd", 1'b1);
                3: cpuRead("rnd_crd", ADDR_W'($urandom));
                default: cpuWrite("rnd_cwr", ADDR_W'($urandom), $urandom, 4'($urandom_range(0, 15)));
            endcase
            @(negedge clk);
        end

        $display("[TB] reset during JTAG read data phase");
        @(negedge clk);
        applyStimulus(0, mkLoad(8'h30, 1'b1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("jrd_rst_mondreg", MonDReg, 32'd0);
        checkOutput("jrd_rst_ready", {31'd0, monitor_ready}, 32'd1);
        checkOutput("jrd_rst_error", {31'd0, monitor_error}, 32'd0);
        checkOutput("jrd_rst_wren", {31'd0, ram_wren}, 32'd0);
        checkOutput("jrd_rst_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
        w0 = wren_count;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("jrd_rst_no_write", wren_count - w0, 0);
        checkOutput("jrd_rst_mondreg_after", MonDReg, 32'd0);
        checkOutput("jrd_rst_ready_after", {31'd0, monitor_ready}, 32'd1);
        model_addr = '0;
        jtagRead("post_rst_rd", 1'b1);

        for (int a = 0; a < DEPTH; a++) begin
            checkOutput($sformatf("mem_%0d", a), ram[a], model_mem[a]);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
